// File: rtl/adder_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_pkg
// Description : Shared defaults, ID width helper and tag type for the
//               adder-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_share_pkg;

    localparam int N_DEF       = 4;
    localparam int W_DEF       = 16;
    localparam int ADD_LAT_DEF = 1;
    // Widest requester index ever needed (N <= 16)
    localparam int ID_W_MAX    = 4;

    function automatic int id_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/adder_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant starting the search at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_grant
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_pick;

    // Requests at or above ptr win first; otherwise wrap to the lowest index.
    assign w_mask    = ~((N'(1) << ptr) - N'(1));
    assign w_hi      = req & w_mask;
    assign w_pick    = (|w_hi) ? w_hi : req;
    assign grant     = en ? (w_pick & (~w_pick + N'(1))) : '0;
    assign any_grant = |grant;

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_arbiter
// Description : Round-robin time-sharing of one registered adder among N
//               requesters, with tagged in-order response return.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter  int N       = N_DEF,
    parameter  int W       = W_DEF,
    parameter  int ADD_LAT = ADD_LAT_DEF,
    localparam int ID_W    = id_width(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*W-1:0]    req_a,
    input  logic [N*W-1:0]    req_b,
    input  logic [N-1:0]      req_cin,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W:0]        add_sum,
    output logic [N-1:0]      rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W:0]        rsp_sum,
    output logic [ID_W+1:0]   in_flight
);

    logic [N-1:0]    w_grant;
    logic [ID_W-1:0] w_grant_id;
    logic            w_any_grant;
    logic [ID_W-1:0] r_ptr;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_sel_cin;
    logic [W-1:0]    r_add_a;
    logic [W-1:0]    r_add_b;
    logic            r_add_cin;
    tag_t            r_tag [ADD_LAT+1];
    tag_t            w_last;
    logic [ID_W+1:0] r_in_flight;

    rr_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_ptr),
        .en        (~reset),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .any_grant (w_any_grant)
    );

    assign req_ready = w_grant;

    if (N == 1) begin : g_ptr_fixed
        assign r_ptr = '0;
    end else begin : g_ptr_rr
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ptr <= '0;
            end else if (w_any_grant) begin
                r_ptr <= (w_grant_id == ID_W'(N - 1)) ? '0 : w_grant_id + ID_W'(1);
            end
        end
    end

    // One-hot grant lets the operand select be a plain OR; no grant yields zeros.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_a   = w_sel_a | req_a[i*W +: W];
                w_sel_b   = w_sel_b | req_b[i*W +: W];
                w_sel_cin = w_sel_cin | req_cin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else begin
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_add_cin <= w_sel_cin;
        end
    end

    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign add_cin = r_add_cin;

    // Stage 0 pairs with the issue registers; stage ADD_LAT pairs with add_sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= ADD_LAT; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= tag_t'{valid: w_any_grant, id: ID_W_MAX'(w_grant_id)};
            for (int s = 1; s <= ADD_LAT; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    assign w_last    = r_tag[ADD_LAT];
    assign rsp_valid = w_last.valid ? (N'(1) << w_last.id) : '0;
    assign rsp_id    = w_last.valid ? w_last.id[ID_W-1:0] : '0;
    assign rsp_sum   = w_last.valid ? add_sum : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_flight <= '0;
        end else begin
            case ({w_any_grant, w_last.valid})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign in_flight = r_in_flight;

endmodule
`default_nettype wire
